mac_fifo_loader: RTL and testbench
==================================

# mac_fifo_loader

Memory-side writer for the vectored MAC/FIFO array. On a `start` pulse it reads `DATA_WIDTH` A-operand rows and one B-operand row from a synchronous memory. It pushes each row into its dedicated input FIFO: A-FIFO k receives row k, and the B-FIFO receives the B row. The block honours each FIFO's full flag and signals completion so the MAC controller can begin draining.

## Interface
- `DATA_WIDTH`, 8: number of A-FIFOs and 8-bit lanes per memory word.
- `ADDR_W`, 16: memory address width.
- `clk`  in  1  sole clock; memory and FIFO write side run on it.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a load when sampled high in IDLE; ignored in every other state.
- `a_base`  in  ADDR_W  address of A row 0; captured on accepted `start`.
- `b_base`  in  ADDR_W  address of the B row; captured on accepted `start`.
- `busy`  out  1  high while a load is in progress; reset 0.
- `done`  out  1  one-cycle pulse after the last FIFO write; reset 0.
- `mem_rden`  out  1  registered read strobe; reset 0.
- `mem_addr`  out  ADDR_W  registered read address; reset 0.
- `mem_rdata`  in  [7:0] x DATA_WIDTH  read data, valid exactly one cycle after `mem_rden`.
- `fifo_wrdata`  out  [7:0] x DATA_WIDTH  row data shared by all FIFOs, driven from a capture register; reset all 0.
- `fifo_wrreq`  out  DATA_WIDTH+1  one-hot write request; bits 0..DATA_WIDTH-1 are the A-FIFOs, bit DATA_WIDTH is the B-FIFO; reset 0.
- `fifo_wrfull`  in  DATA_WIDTH+1  full flag per FIFO, same bit order as `fifo_wrreq`.

## Operation
- FSM states: IDLE, RD, WAIT, WR, DONE.
  - IDLE: `start` captures the bases, clears the row counter `r`, and moves to RD.
  - RD: `mem_rden`=1, `mem_addr` = `a_base`+r for r<DATA_WIDTH, else `b_base`. Moves to WAIT.
  - WAIT: capture `mem_rdata` into the row register. Moves to WR.
  - WR: `fifo_wrreq[r]` = !`fifo_wrfull[r]`; all other bits 0.
    - If not full: write completes, r increments, and the FSM moves to RD if r was below DATA_WIDTH, else to DONE.
    - If full: stay in WR, no request, no memory read.
  - DONE: `done`=1 for one cycle, then IDLE.
- `busy` = (state != IDLE && state != DONE).
- Rows per load: DATA_WIDTH+1. The row counter is $clog2(DATA_WIDTH+1) bits wide.
- Address arithmetic is modulo 2^ADDR_W; `a_base`+r wraps silently.
- `fifo_wrreq` is combinational from state, r and `fifo_wrfull`. It is never asserted into a full FIFO and is never multi-hot.
- `fifo_wrdata` holds its last value outside WR.
- `start` while `busy`, or during DONE, is dropped with no queueing.
- `rst_n` low at any point forces IDLE and all outputs to their reset values asynchronously. Writes already completed stay in the FIFOs; this block never clears FIFOs. The row in flight is abandoned.

## Timing
- Timing is referenced to `start` high in cycle 0.
- For row n (0..DATA_WIDTH): RD in cycle 1+3n, WAIT in 2+3n, WR in 3+3n when unstalled.
- DATA_WIDTH=8: last WR in cycle 27, `done` in cycle 28, `busy` high cycles 1–27, next `start` accepted from cycle 29.
- Each cycle of `fifo_wrfull` high during WR adds one cycle and delays all later rows.
- Memory read latency is fixed at 1. `mem_rdata` is sampled only in WAIT.

## Structure
- Shared package `mac_fifo_pkg` holds:
  - the state enum `loader_state_t`;
  - the localparam `MEM_LAT`=1;
  - the row-lane typedef `lane_t` = logic [7:0]. The MAC/FIFO array uses the same package.
- No sub-module: single FSM plus row counter and capture register.

## Test plan
- Plain load, DATA_WIDTH=8, `a_base`=0x0100, `b_base`=0x0200, memory word at addr = {8{addr[7:0]}}:
  - A-FIFO k receives 8 lanes of 0x00+k and the B-FIFO receives 0x00 lanes;
  - exactly 9 one-hot writes; `done` in cycle 28.
- Backpressure: hold `fifo_wrfull[3]` high for 5 cycles when row 3 reaches WR.
  - No `fifo_wrreq[3]` and no `mem_rden` while full; write occurs in the first cycle full drops; `done` in cycle 33.
- Wrap: `a_base`=0xFFFE.
  - Addresses issued are 0xFFFE, 0xFFFF, 0x0000..0x0005, then `b_base`.
- `start` re-pulsed in cycles 5 and 28: both ignored; exactly one load occurs.
- Reset mid-load: deassert `rst_n` during WR of row 4.
  - Outputs go to 0 the same cycle; FIFOs hold exactly 4 rows; a subsequent `start` performs a full 9-row load from r=0.

Source files
------------

// File: rtl/mac_fifo_pkg.sv
// Shared types for the vectored MAC/FIFO array and its memory-side loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mac_fifo_pkg;

    // Loader FSM states. The per-row sequence is RD -> WAIT -> WR.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } loader_state_t;

    // Synchronous memory read latency in cycles. WAIT exists to cover this one cycle.
    localparam int MEM_LAT = 1;

    // One 8-bit lane of a memory row.
    typedef logic [7:0] lane_t;

endpackage

// File: rtl/mac_fifo_loader.sv
// Loads DATA_WIDTH A rows and one B row from memory into their dedicated FIFOs.
// Latency: 3 cycles per row when unstalled; done is asserted 3*(DATA_WIDTH+1)+1 cycles after start.
// Backpressure: a full target FIFO holds the FSM in WR, with no write request and no memory read.
module mac_fifo_loader
    import mac_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             a_base,
    input  logic [ADDR_W-1:0]             b_base,
    output logic                          busy,
    output logic                          done,
    output logic                          mem_rden,
    output logic [ADDR_W-1:0]             mem_addr,
    input  lane_t [DATA_WIDTH-1:0]        mem_rdata,
    output lane_t [DATA_WIDTH-1:0]        fifo_wrdata,
    output logic  [DATA_WIDTH:0]          fifo_wrreq,
    input  logic  [DATA_WIDTH:0]          fifo_wrfull
);

    localparam int ROW_W = $clog2(DATA_WIDTH + 1);
    // Row index of the B row. Rows below this index are A rows.
    localparam logic [ROW_W-1:0] B_ROW = ROW_W'(DATA_WIDTH);

    loader_state_t      state_q;
    loader_state_t      state_d;
    logic [ROW_W-1:0]   row_q;
    logic [ROW_W-1:0]   row_nxt;
    logic [ADDR_W-1:0]  a_base_q;
    logic [ADDR_W-1:0]  b_base_q;
    logic [ADDR_W-1:0]  rd_a_base;
    logic [ADDR_W-1:0]  rd_b_base;
    logic [ADDR_W-1:0]  addr_d;
    logic               wr_ok;

    // The current row's write completes this cycle when its FIFO has room.
    assign wr_ok = (state_q == ST_WR) && !fifo_wrfull[row_q];

    // Next-state logic. A full FIFO in WR holds the state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RD;
            ST_RD:   state_d = ST_WAIT;
            ST_WAIT: state_d = ST_WR;
            ST_WR:   if (wr_ok) state_d = (row_q < B_ROW) ? ST_RD : ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Address of the next read. On a start from IDLE the bases are not registered
    // yet, so the live inputs are used for row 0.
    always_comb begin
        row_nxt   = (state_q == ST_IDLE) ? '0 : row_q + 1'b1;
        rd_a_base = (state_q == ST_IDLE) ? a_base : a_base_q;
        rd_b_base = (state_q == ST_IDLE) ? b_base : b_base_q;
        addr_d    = (row_nxt < B_ROW) ? rd_a_base + ADDR_W'(row_nxt) : rd_b_base;
    end

    // FSM state, row counter and the captured base addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start) begin
                row_q    <= '0;
                a_base_q <= a_base;
                b_base_q <= b_base;
            end else if (wr_ok) begin
                row_q <= row_nxt;
            end
        end
    end

    // Registered read strobe and address: both are valid for exactly the RD cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rden <= 1'b0;
            mem_addr <= '0;
        end else begin
            mem_rden <= (state_d == ST_RD);
            if (state_d == ST_RD) mem_addr <= addr_d;
        end
    end

    // Row capture register. Memory data is valid during WAIT; the value is held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wrdata <= '0;
        end else if (state_q == ST_WAIT) begin
            fifo_wrdata <= mem_rdata;
        end
    end

    // One-hot write request. It is never raised into a full FIFO.
    always_comb begin
        fifo_wrreq = '0;
        if (wr_ok) fifo_wrreq[row_q] = 1'b1;
    end

    assign busy = (state_q == ST_RD) || (state_q == ST_WAIT) || (state_q == ST_WR);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_mac_fifo_loader.sv
// Bench for mac_fifo_loader: directed and randomized loads checked against a row-level model.
// Latency: n/a.
// Backpressure: a single FIFO full window is driven per load.
module tb_mac_fifo_loader;

    localparam int DW = 8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a_base;
    logic [15:0] b_base;
    logic        busy;
    logic        done;
    logic        mem_rden;
    logic [15:0] mem_addr;
    logic [63:0] mem_rdata;
    logic [63:0] fifo_wrdata;
    logic [8:0]  fifo_wrreq;
    logic [8:0]  fifo_wrfull;

    typedef struct {
        int          idx;
        logic [63:0] dat;
    } wr_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          start_cyc = 0;
    logic [7:0]  salt     = 8'h00;

    wr_t         wr_q[$];
    logic [15:0] addr_q[$];
    int          done_q[$];
    int          busy_q[$];
    int          onehot_bad_q[$];
    int          full_bad_q[$];
    int          rden_full_q[$];

    mac_fifo_loader #(.DATA_WIDTH(DW), .ADDR_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a_base      (a_base),
        .b_base      (b_base),
        .busy        (busy),
        .done        (done),
        .mem_rden    (mem_rden),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .fifo_wrdata (fifo_wrdata),
        .fifo_wrreq  (fifo_wrreq),
        .fifo_wrfull (fifo_wrfull)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents: lane i of the word at addr is addr[7:0] ^ (salt*(i+1)).
    function automatic logic [63:0] mem_word(input logic [15:0] addr);
        logic [63:0] w;
        logic [7:0]  m;
        w = '0;
        for (int i = 0; i < DW; i++) begin
            m = 8'(int'(salt) * (i + 1));
            w[i*8 +: 8] = addr[7:0] ^ m;
        end
        return w;
    endfunction

    // Synchronous memory with a one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rden) mem_rdata <= mem_word(mem_addr);
    end

    // Observer: the FIFO model plus the protocol event logs.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rden) begin
                addr_q.push_back(mem_addr);
                if (fifo_wrfull != '0) rden_full_q.push_back(cyc);
            end
            if (busy) busy_q.push_back(cyc);
            if (done) done_q.push_back(cyc - start_cyc);
            if (fifo_wrreq != '0) begin
                if ($countones(fifo_wrreq) != 1) onehot_bad_q.push_back(cyc);
                if ((fifo_wrreq & fifo_wrfull) != '0) full_bad_q.push_back(cyc);
                for (int i = 0; i <= DW; i++) begin
                    if (fifo_wrreq[i]) wr_q.push_back('{idx: i, dat: fifo_wrdata});
                end
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_logs();
        wr_q.delete();
        addr_q.delete();
        done_q.delete();
        busy_q.delete();
        onehot_bad_q.delete();
        full_bad_q.delete();
        rden_full_q.delete();
    endtask

    // Starts one load, then runs a fixed window of cycles. Start is re-pulsed at
    // offsets p1/p2, and FIFO stall_row reads full for stall_len cycles from the
    // moment that row first reaches WR.
    task automatic do_load(input logic [15:0] a, input logic [15:0] b,
                           input int stall_row, input int stall_len,
                           input int p1, input int p2);
        int rel;
        clear_logs();
        @(posedge clk); #1;
        a_base    = a;
        b_base    = b;
        start     = 1'b1;
        start_cyc = cyc;
        for (int i = 0; i < 48; i++) begin
            @(posedge clk); #1;
            rel         = cyc - start_cyc;
            start       = (rel == p1) || (rel == p2);
            fifo_wrfull = '0;
            if (stall_row >= 0 && rel >= 3 + 3 * stall_row && rel < 3 + 3 * stall_row + stall_len)
                fifo_wrfull[stall_row] = 1'b1;
        end
        start       = 1'b0;
        fifo_wrfull = '0;
    endtask

    // Compares the logs with a load of DW+1 rows: addresses a+k (mod 2^16) then b,
    // row k landing in FIFO k, and done/busy timing shifted by the stall length.
    task automatic check_load(input logic [15:0] a, input logic [15:0] b, input int stall_len);
        logic [15:0] ea;
        check("done_cycle", done_q.size() == 1 ? done_q[0] : -1, 28 + stall_len);
        check("busy_cycles", busy_q.size(), 27 + stall_len);
        check("read_count", addr_q.size(), DW + 1);
        check("write_count", wr_q.size(), DW + 1);
        check("onehot", onehot_bad_q.size(), 0);
        check("wr_into_full", full_bad_q.size(), 0);
        check("rden_while_full", rden_full_q.size(), 0);
        for (int k = 0; k <= DW; k++) begin
            ea = (k < DW) ? 16'(a + 16'(k)) : b;
            check($sformatf("addr%0d", k), k < addr_q.size() ? addr_q[k] : 'x, ea);
            check($sformatf("wr_fifo%0d", k), k < wr_q.size() ? wr_q[k].idx : -1, k);
            check($sformatf("wr_data%0d", k), k < wr_q.size() ? wr_q[k].dat : 'x, mem_word(ea));
        end
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        int          rrow;
        int          rlen;

        rst_n       = 1'b1;
        start       = 1'b0;
        a_base      = '0;
        b_base      = '0;
        fifo_wrfull = '0;
        mem_rdata   = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rden", mem_rden, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wrreq", fifo_wrreq, 0);
        check("rst_wrdata", fifo_wrdata, 0);
        rst_n = 1'b1;

        // Plain load; start re-pulsed mid-load and during DONE must be dropped.
        salt = 8'h00;
        do_load(16'h0100, 16'h0200, -1, 0, 5, 28);
        check_load(16'h0100, 16'h0200, 0);
        check("plain_a3_lanes", wr_q.size() > 3 ? wr_q[3].dat : 'x, 64'h0303030303030303);

        // Backpressure on A-FIFO 3 for five cycles.
        do_load(16'h0100, 16'h0200, 3, 5, -1, -1);
        check_load(16'h0100, 16'h0200, 5);

        // Address wrap.
        salt = 8'($urandom);
        do_load(16'hFFFE, 16'h1234, -1, 0, -1, -1);
        check_load(16'hFFFE, 16'h1234, 0);

        // Reset during WR of row 4 abandons the row; completed writes stay.
        clear_logs();
        salt = 8'h00;
        @(posedge clk); #1;
        a_base    = 16'h0100;
        b_base    = 16'h0200;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("pre_rst_wrreq", fifo_wrreq, 9'h010);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_rden", mem_rden, 0);
        check("midrst_addr", mem_addr, 0);
        check("midrst_wrreq", fifo_wrreq, 0);
        check("midrst_wrdata", fifo_wrdata, 0);
        repeat (2) @(posedge clk);
        check("midrst_rows", wr_q.size(), 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("midrst_fifo%0d", k), k < wr_q.size() ? wr_q[k].idx : -1, k);
        #1 rst_n = 1'b1;
        do_load(16'h0100, 16'h0200, -1, 0, -1, -1);
        check_load(16'h0100, 16'h0200, 0);

        // Randomized loads with one random stall each.
        for (int t = 0; t < 3; t++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            salt = 8'($urandom);
            rrow = $urandom_range(0, DW);
            rlen = $urandom_range(1, 6);
            do_load(ra, rb, rrow, rlen, -1, -1);
            check_load(ra, rb, rlen);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
